// File: rtl/change_scheduler.sv
// rtl/change_scheduler.sv - greedy coin-change planner and dispenser over four coin tubes
module change_scheduler #(
  parameter int TUBE_DEPTH = 15,
  parameter int AMT_W      = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             refill,
  output logic             eject10,
  output logic             eject5,
  output logic             eject2,
  output logic             eject1,
  output logic             done,
  output logic             fail,
  output logic             busy,
  output logic [3:0]       cnt10,
  output logic [3:0]       cnt5,
  output logic [3:0]       cnt2,
  output logic [3:0]       cnt1
);

  typedef enum logic [2:0] {IDLE, PLAN, DISPENSE, DONE, FAIL} state_t;

  localparam logic [3:0]       FULL = 4'(TUBE_DEPTH);
  localparam logic [AMT_W-1:0] TEN  = AMT_W'(10);
  localparam logic [AMT_W-1:0] FIVE = AMT_W'(5);
  localparam logic [AMT_W-1:0] TWO  = AMT_W'(2);

  state_t           state, state_nxt;
  logic [AMT_W-1:0] amount;
  logic [3:0]       n10, n5, n2, n1;

  logic [AMT_W-1:0] q10, q5, q2, r1, r2, r3, r4;
  logic [3:0]       p10, p5, p2, p1;
  logic [5:0]       n_total;
  logic             accept;

  assign accept    = req_valid && req_ready;
  assign req_ready = (state == IDLE) && !refill;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign fail      = (state == FAIL);
  assign n_total   = 6'(n10) + 6'(n5) + 6'(n2) + 6'(n1);

  // Coins leave in value order; each eject is chosen purely from the remaining plan.
  assign eject10 = (state == DISPENSE) && (n10 != 4'd0);
  assign eject5  = (state == DISPENSE) && (n10 == 4'd0) && (n5 != 4'd0);
  assign eject2  = (state == DISPENSE) && (n10 == 4'd0) && (n5 == 4'd0) && (n2 != 4'd0);
  assign eject1  = (state == DISPENSE) && (n10 == 4'd0) && (n5 == 4'd0) && (n2 == 4'd0)
                   && (n1 != 4'd0);

  // Greedy plan limited by what each tube actually holds.
  always_comb begin
    q10 = amount / TEN;
    p10 = (q10 > AMT_W'(cnt10)) ? cnt10 : q10[3:0];
    r1  = amount - AMT_W'(p10) * TEN;
    q5  = r1 / FIVE;
    p5  = (q5 > AMT_W'(cnt5)) ? cnt5 : q5[3:0];
    r2  = r1 - AMT_W'(p5) * FIVE;
    q2  = r2 / TWO;
    p2  = (q2 > AMT_W'(cnt2)) ? cnt2 : q2[3:0];
    r3  = r2 - AMT_W'(p2) * TWO;
    p1  = (r3 > AMT_W'(cnt1)) ? cnt1 : r3[3:0];
    r4  = r3 - AMT_W'(p1);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = PLAN;
      PLAN: begin
        if (r4 != '0)                              state_nxt = FAIL;
        else if ((p10 | p5 | p2 | p1) == 4'd0)     state_nxt = DONE;
        else                                       state_nxt = DISPENSE;
      end
      DISPENSE: if (n_total == 6'd1) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      FAIL:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Latched request, remaining plan and tube inventory.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      amount <= '0;
      n10    <= 4'd0;
      n5     <= 4'd0;
      n2     <= 4'd0;
      n1     <= 4'd0;
      cnt10  <= FULL;
      cnt5   <= FULL;
      cnt2   <= FULL;
      cnt1   <= FULL;
    end else begin
      if (accept) amount <= req_amount;
      if ((state == IDLE) && refill) begin
        cnt10 <= FULL;
        cnt5  <= FULL;
        cnt2  <= FULL;
        cnt1  <= FULL;
      end
      if (state == PLAN) begin
        n10 <= p10;
        n5  <= p5;
        n2  <= p2;
        n1  <= p1;
      end
      if (eject10) begin n10 <= n10 - 4'd1; cnt10 <= cnt10 - 4'd1; end
      if (eject5)  begin n5  <= n5  - 4'd1; cnt5  <= cnt5  - 4'd1; end
      if (eject2)  begin n2  <= n2  - 4'd1; cnt2  <= cnt2  - 4'd1; end
      if (eject1)  begin n1  <= n1  - 4'd1; cnt1  <= cnt1  - 4'd1; end
    end
  end

endmodule

// File: tb/tb_change_scheduler.sv
// tb/tb_change_scheduler.sv - self-checking bench for change_scheduler
module tb_change_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic [5:0] req_amount = '0;
  logic       req_ready;
  logic       refill = 1'b0;
  logic       eject10, eject5, eject2, eject1, done, fail, busy;
  logic [3:0] cnt10, cnt5, cnt2, cnt1;

  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt[4];

  change_scheduler #(.TUBE_DEPTH(15), .AMT_W(6)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .refill(refill),
    .eject10(eject10), .eject5(eject5), .eject2(eject2), .eject1(eject1),
    .done(done), .fail(fail), .busy(busy),
    .cnt10(cnt10), .cnt5(cnt5), .cnt2(cnt2), .cnt1(cnt1)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          amount;
    bit          exp_fail;
    int          exp_ejects;
    logic [15:0] exp_cnts;
  } vec_t;

  function automatic logic [5:0] ev();
    return {eject10, eject5, eject2, eject1, done, fail};
  endfunction

  function automatic int coin_val(input int i);
    case (i)
      0: return 10;
      1: return 5;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_cnts(input string nm);
    chk({nm, "_cnt10"}, int'(cnt10), m_cnt[0]);
    chk({nm, "_cnt5"},  int'(cnt5),  m_cnt[1]);
    chk({nm, "_cnt2"},  int'(cnt2),  m_cnt[2]);
    chk({nm, "_cnt1"},  int'(cnt1),  m_cnt[3]);
  endtask

  task automatic model_full();
    for (int i = 0; i < 4; i++) m_cnt[i] = 15;
  endtask

  // Called at the negedge just before the accepting edge; follows the request to IDLE.
  task automatic track(input int a, input bit noise, input bit hold_refill,
                       output int n_ej, output bit failed_obs);
    int         q[$];
    int         n[4];
    int         rem;
    logic [5:0] e;
    bit         mfail;
    rem = a;
    for (int i = 0; i < 4; i++) begin
      n[i] = rem / coin_val(i);
      if (n[i] > m_cnt[i]) n[i] = m_cnt[i];
      rem -= n[i] * coin_val(i);
      for (int k = 0; k < n[i]; k++) q.push_back(i);
    end
    mfail = (rem != 0);
    if (mfail) q.delete();
    @(negedge clock);
    req_valid = noise;
    req_amount = 6'($urandom_range(0, 63));
    refill = hold_refill;
    chk("plan_busy", int'(busy), 1);
    chk("plan_ready", int'(req_ready), 0);
    chk("plan_quiet", int'(ev()), 0);
    n_ej = 0;
    foreach (q[k]) begin
      @(negedge clock);
      e = 6'b100000 >> q[k];
      chk("eject_seq", int'(ev()), int'(e));
      if (ev()[5:2] != 4'd0) n_ej++;
    end
    @(negedge clock);
    chk("terminal", int'(ev()), mfail ? 1 : 2);
    failed_obs = (ev() == 6'b000001);
    req_valid = 1'b0;
    refill = 1'b0;
    if (!mfail) for (int i = 0; i < 4; i++) m_cnt[i] -= n[i];
    @(negedge clock);
    chk("post_busy", int'(busy), 0);
    chk_cnts("post");
  endtask

  task automatic issue(input int a, input bit noise, input bit hold_refill,
                       output int n_ej, output bit failed_obs);
    @(negedge clock);
    chk("issue_ready", int'(req_ready), 1);
    req_valid = 1'b1;
    req_amount = 6'(a);
    track(a, noise, hold_refill, n_ej, failed_obs);
  endtask

  vec_t vecs[4];
  int   nej;
  bit   fobs;

  initial begin
    vecs[0] = '{amount: 38, exp_fail: 1'b0, exp_ejects: 6, exp_cnts: 16'hCEEE};
    vecs[1] = '{amount: 0,  exp_fail: 1'b0, exp_ejects: 0, exp_cnts: 16'hCEEE};
    vecs[2] = '{amount: 63, exp_fail: 1'b0, exp_ejects: 8, exp_cnts: 16'h6EDD};
    vecs[3] = '{amount: 15, exp_fail: 1'b0, exp_ejects: 2, exp_cnts: 16'h5DDD};
    model_full();

    // Reset state, both during and after reset.
    repeat (2) @(negedge clock);
    chk("rst_outputs", int'(ev()), 0);
    chk("rst_busy", int'(busy), 0);
    chk_cnts("rst");
    reset = 1'b1;
    @(negedge clock);
    chk("rel_ready", int'(req_ready), 1);
    chk("rel_busy", int'(busy), 0);
    chk("rel_ejects", int'(ev()), 0);
    chk_cnts("rel");

    // Directed table from full tubes.
    for (int i = 0; i < 4; i++) begin
      issue(vecs[i].amount, 1'b0, 1'b0, nej, fobs);
      chk("tbl_fail", int'(fobs), int'(vecs[i].exp_fail));
      chk("tbl_ejects", nej, vecs[i].exp_ejects);
      chk("tbl_cnts", int'({cnt10, cnt5, cnt2, cnt1}), int'(vecs[i].exp_cnts));
    end

    // Drain the 1-baht tube, then an unpayable 6 and a payable 4.
    @(negedge clock);
    refill = 1'b1;
    @(negedge clock);
    refill = 1'b0;
    model_full();
    chk_cnts("refill");
    repeat (15) issue(1, 1'b0, 1'b0, nej, fobs);
    chk("drain_cnt1", int'(cnt1), 0);
    issue(6, 1'b0, 1'b0, nej, fobs);
    chk("six_fail", int'(fobs), 1);
    chk("six_ejects", nej, 0);
    chk("six_cnts", int'({cnt10, cnt5, cnt2, cnt1}), 16'hFFF0);
    issue(4, 1'b0, 1'b0, nej, fobs);
    chk("four_ejects", nej, 2);
    chk("four_cnt2", int'(cnt2), 13);

    // Refill and request together: refill wins, request accepted afterwards.
    @(negedge clock);
    refill = 1'b1;
    req_valid = 1'b1;
    req_amount = 6'd5;
    #1;
    chk("rv_ready", int'(req_ready), 0);
    @(negedge clock);
    chk("rv_busy", int'(busy), 0);
    model_full();
    chk_cnts("rv");
    refill = 1'b0;
    #1;
    chk("rv_ready2", int'(req_ready), 1);
    track(5, 1'b0, 1'b0, nej, fobs);
    chk("rv_ejects", nej, 1);

    // Reset during dispense of 38, after the second coin.
    @(negedge clock);
    req_valid = 1'b1;
    req_amount = 6'd38;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    chk("abort_e1", int'(ev()), 32);
    @(negedge clock);
    chk("abort_e2", int'(ev()), 32);
    reset = 1'b0;
    #1;
    chk("abort_quiet", int'(ev()), 0);
    chk("abort_busy", int'(busy), 0);
    model_full();
    chk_cnts("abort");
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_ready", int'(req_ready), 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("abort_idle", int'({busy, ev()}), 0);
    end

    // Randomized requests against the model, with noise while busy.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clock);
        refill = 1'b1;
        @(negedge clock);
        refill = 1'b0;
        model_full();
        chk_cnts("rnd_refill");
      end
      issue(int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), nej, fobs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/change_scheduler.md
CHANGE_SCHEDULER -- requirements
Module: change_scheduler

Interface
REQ-001 Parameter TUBE_DEPTH, default 15; coin capacity of each tube and the inventory reset/refill value (max 15).
REQ-002 Parameter AMT_W, default 6; width of the change-amount request.
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  change request present.
REQ-006 req_amount  input  AMT_W  change to return, in baht (0..63).
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 refill  input  1  restock all four tubes to TUBE_DEPTH.
REQ-009 eject10, eject5, eject2, eject1  output  1 each  one-cycle pulse releasing one coin of that value.
REQ-010 done  output  1  one-cycle pulse: request fully paid out.
REQ-011 fail  output  1  one-cycle pulse: request not payable; nothing ejected.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 cnt10, cnt5, cnt2, cnt1  output  4 each  current coin inventory per tube.

Function
REQ-014 FSM states: IDLE, PLAN, DISPENSE, DONE, FAIL.
REQ-015 req_ready shall equal (state==IDLE) && !refill; a request is accepted on an edge where req_valid && req_ready, latching req_amount and moving to PLAN.
REQ-016 PLAN shall last exactly one cycle and compute the greedy plan from the latched amount A: n10=min(A/10,cnt10), r1=A-10*n10; n5=min(r1/5,cnt5), r2=r1-5*n5; n2=min(r2/2,cnt2), r3=r2-2*n2; n1=min(r3,cnt1), r4=r3-n1.
REQ-017 PLAN exits to FAIL if r4!=0, to DONE if n10+n5+n2+n1==0, otherwise to DISPENSE.
REQ-018 DISPENSE shall assert exactly one eject output per cycle, back-to-back with no idle gaps, in the order all 10s, then 5s, then 2s, then 1s.
REQ-019 The matching cnt shall decrement on the same edge that ends each eject cycle.
REQ-020 After the last eject cycle, the FSM shall enter DONE; DONE and FAIL each last one cycle, pulse done or fail respectively, then return to IDLE.
REQ-021 Latency: for a request accepted at edge E0, PLAN occupies cycle E0..E1, the first eject appears in cycle E1..E2, and done appears in the cycle immediately after the last eject; for A=0, done appears in cycle E1..E2.
REQ-022 A failed request shall leave all four counters unchanged; partial payout is forbidden.
REQ-023 refill is honoured only in IDLE: at the edge, all counters load TUBE_DEPTH; refill outside IDLE is ignored.
REQ-024 When refill and req_valid are both high in IDLE, refill wins and the request is not accepted that cycle.
REQ-025 At most one of eject10/5/2/1, done and fail shall be high in any cycle.
REQ-026 req_amount and req_valid are ignored while busy; no request queuing.

Reset
REQ-027 reset low shall immediately force: state IDLE, all eject outputs, done, fail and busy low, and all counters to TUBE_DEPTH.
REQ-028 reset low mid-DISPENSE shall abort the payout; after release, req_ready is high on the first cycle and no pending coins are ejected.

Verification
REQ-029 Reset release -> cnt10/5/2/1=15, req_ready=1, busy=0, all ejects 0.
REQ-030 Request 38 with full tubes -> after one PLAN cycle, ejects 10,10,10,5,2,1 on six consecutive cycles, then done; final counts 12/14/14/14.
REQ-031 Fifteen requests of 1 (draining cnt1 to 0), then request 6 -> fail pulse two cycles after accept, no ejects, counts unchanged; request 4 then pays 2,2 and done.
REQ-032 Request 0 -> done in the cycle after PLAN, no ejects, counts unchanged.
REQ-033 Request 38, reset asserted after the second eject -> outputs low at once, counts back to 15, no further ejects after release.
REQ-034 refill and req_valid both high in IDLE -> req_ready=0, counts go to 15; request is accepted on the next cycle after refill drops.
